// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: word handshake and per-frame config from the TX FIFO.
// The producer drives data/config/valid; the serializer answers with ready.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        parity_mode;
    logic              two_stop;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_mode,
        output two_stop,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_mode,
        input  two_stop,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART framer with internal baud divider.
// Start bit, DATA_W data bits LSB first, optional parity, one or two stops.
module uart_tx_serializer #(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_serializer_if.slave tx_if,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        mode_q, mode_d;
    logic              two_q, two_d;
    logic              serial_q, serial_d;
    logic              bit_end;
    logic              par_en;
    logic              par_bit;

    assign bit_end = (baud_q == BAUD_LAST);
    assign par_en  = (mode_q == 2'b01) || (mode_q == 2'b10);
    // Odd mode is the inverse of the even (XOR) parity of the latched word.
    assign par_bit = (^data_q) ^ (mode_q == 2'b10);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        mode_d  = mode_q;
        two_d   = two_q;
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + CW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (tx_if.tx_valid) begin
                    data_d  = tx_if.tx_data;
                    mode_d  = tx_if.parity_mode;
                    two_d   = tx_if.two_stop;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (two_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed for the upcoming state so it is registered.
        serial_d = 1'b1;
        unique case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = data_q[bit_d];
            PARITY:  serial_d = par_bit;
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            mode_q   <= 2'b00;
            two_q    <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            two_q    <= two_d;
            serial_q <= serial_d;
        end
    end

    assign tx_if.tx_ready = (state_q == IDLE);
    assign serial_out     = serial_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == STOP) && bit_end &&
                            (!two_q || bit_q == BW'(1));
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame vectors plus back-to-back,
// mid-frame input changes and asynchronous reset sequences.
module tb_uart_tx_serializer;
    localparam int DW = 8;
    localparam int BD = 4;

    logic clk;
    logic reset;
    logic serial_out;
    logic busy;
    logic done;

    uart_tx_serializer_if #(.DATA_W(DW)) tx_if ();

    uart_tx_serializer #(
        .DATA_W  (DW),
        .BAUD_DIV(BD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_if     (tx_if),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       two;
        logic       has_par;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit toggle);
        logic ebit[12];
        int   nb;
        int   w;
        int   line_bad;
        int   hs_bad;
        int   first_done;
        int   ndone;
        logic exp_l;
        ebit[0] = 1'b0;
        for (int i = 0; i < 8; i++) ebit[1+i] = v.data[i];
        nb = 9;
        if (v.has_par) begin
            ebit[nb] = v.exp_par;
            nb++;
        end
        ebit[nb] = 1'b1;
        nb++;
        if (v.two) begin
            ebit[nb] = 1'b1;
            nb++;
        end
        @(negedge clk);
        tx_if.tx_data     = v.data;
        tx_if.parity_mode = v.mode;
        tx_if.two_stop    = v.two;
        tx_if.tx_valid    = 1'b1;
        w = 0;
        while (!tx_if.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!tx_if.tx_ready) begin
            chk({tag, " ready_wait"}, 32'(tx_if.tx_ready), 32'd1);
            tx_if.tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
        line_bad   = 0;
        hs_bad     = 0;
        first_done = -1;
        ndone      = 0;
        for (int k = 0; k <= v.exp_len; k++) begin
            if (toggle && k == 6) begin
                tx_if.tx_data     = ~v.data;
                tx_if.parity_mode = v.mode ^ 2'b11;
                tx_if.two_stop    = ~v.two;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            if (k < v.exp_len) begin
                exp_l = (k / BD < nb) ? ebit[k/BD] : 1'b1;
                if (serial_out !== exp_l) line_bad++;
                if (tx_if.tx_ready !== 1'b0 || busy !== 1'b1) hs_bad++;
            end else begin
                chk({tag, " end_state"},
                    32'({serial_out, tx_if.tx_ready, busy, done}),
                    32'b1100);
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " line_mismatch_cycles"}, 32'(line_bad), 32'd0);
        chk({tag, " ready_busy_bad_cycles"}, 32'(hs_bad), 32'd0);
        chk({tag, " done_cycle"}, 32'(first_done), 32'(v.exp_len - 1));
        chk({tag, " done_count"}, 32'(ndone), 32'd1);
    endtask

    logic [7:0] words[3];
    logic       rec_line[130];
    logic       rec_done[130];

    initial begin
        int   idx;
        int   nrec;
        bit   rec;
        bit   acc;
        int   bad;
        int   dcnt;
        logic exp_l;
        logic exp_d;
        int   f;
        int   p;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 40};
        vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 44};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0, 44};
        vecs[3] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 44};
        vecs[4] = '{8'h07, 2'b11, 1'b0, 1'b0, 1'b0, 40};
        vecs[5] = '{8'hA3, 2'b10, 1'b1, 1'b1, 1'b1, 48};
        vecs[6] = '{8'hFF, 2'b01, 1'b1, 1'b1, 1'b0, 48};

        reset             = 1'b1;
        tx_if.tx_valid    = 1'b0;
        tx_if.tx_data     = '0;
        tx_if.parity_mode = 2'b00;
        tx_if.two_stop    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({serial_out, tx_if.tx_ready, busy, done}),
            32'b1100);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 32'({tx_if.tx_ready, serial_out}), 32'b11);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        run_vec("toggle_a3", vecs[5], 1'b1);
        run_vec("toggle_07", vecs[1], 1'b1);

        // Back-to-back: three words with tx_valid held high.
        words[0] = 8'h11;
        words[1] = 8'hC4;
        words[2] = 8'h3E;
        idx  = 0;
        nrec = 0;
        rec  = 0;
        @(negedge clk);
        tx_if.parity_mode = 2'b00;
        tx_if.two_stop    = 1'b0;
        tx_if.tx_data     = words[0];
        tx_if.tx_valid    = 1'b1;
        for (int c = 0; c < 250; c++) begin
            acc = tx_if.tx_ready && tx_if.tx_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                rec = 1;
                idx++;
                if (idx < 3) tx_if.tx_data = words[idx];
                else tx_if.tx_valid = 1'b0;
            end
            if (rec && nrec < 130) begin
                rec_line[nrec] = serial_out;
                rec_done[nrec] = done;
                nrec++;
            end
            @(negedge clk);
        end
        tx_if.tx_valid = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd3);
        bad  = 0;
        dcnt = 0;
        for (int k = 0; k < 130; k++) begin
            f = k / 41;
            p = k % 41;
            exp_l = 1'b1;
            exp_d = 1'b0;
            if (f < 3 && p < 40) begin
                if (p / BD == 0) exp_l = 1'b0;
                else if (p / BD <= 8) exp_l = words[f][p/BD-1];
                if (p == 39) exp_d = 1'b1;
            end
            if (k < nrec) begin
                if (rec_line[k] !== exp_l) bad++;
                if (rec_done[k] !== exp_d) bad++;
                if (rec_done[k] === 1'b1) dcnt++;
            end else begin
                bad++;
            end
        end
        chk("b2b_stream_bad_cycles", 32'(bad), 32'd0);
        chk("b2b_done_pulses", 32'(dcnt), 32'd3);

        // Asynchronous reset in the middle of the DATA state.
        @(negedge clk);
        tx_if.tx_data     = 8'h5A;
        tx_if.parity_mode = 2'b00;
        tx_if.two_stop    = 1'b0;
        tx_if.tx_valid    = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre_reset_line_busy", 32'({serial_out, busy}), 32'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            32'({serial_out, tx_if.tx_ready, busy, done}), 32'b1100);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release_ready", 32'({tx_if.tx_ready, busy}), 32'b10);
        run_vec("after_reset", '{8'hC3, 2'b01, 1'b0, 1'b1, 1'b0, 44}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
